pad_driver_ctrl: RTL
====================

PAD_DRIVER_CTRL -- requirements
Module: pad_driver_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of pad bits.
REQ-002 Parameter RISE_DLY, default 1: cycles from a 0->1 data request to a 0->1 drive on a bit; range 0..15.
REQ-003 Parameter FALL_DLY, default 3: cycles from a 1->0 data request to a 1->0 drive on a bit; range 0..15.
REQ-004 Parameter TURN_DLY, default 2: dead cycles on each direction change; range 1..15.
REQ-005 Parameter PULL_MODE, default 0: 0 none, 1 pullup, 2 pulldown, 3 bus keeper.
REQ-006 The block has exactly one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port oe, input, 1: drive request; 1 means drive the pad, 0 means release it.
REQ-010 Port dout, input, WIDTH: requested pad data.
REQ-011 Port pad_i, input, WIDTH: sampled pad level.
REQ-012 Port pad_o, output, WIDTH: delayed drive data.
REQ-013 Port pad_oe, output, 1: pad driver enable.
REQ-014 Port pad_pu, output, WIDTH: per-bit pullup enable.
REQ-015 Port pad_pd, output, WIDTH: per-bit pulldown enable.
REQ-016 Port din, output, WIDTH: pad_i registered once.
REQ-017 Port busy, output, 1: high in the TURN_ON and TURN_OFF states.
REQ-018 Port contention, output, WIDTH: per-bit drive/sense mismatch flag.

Function
REQ-019 Direction FSM states: HIZ, TURN_ON, DRIVE, TURN_OFF.
REQ-020 Transitions:
- HIZ -> TURN_ON on oe=1.
- TURN_ON -> DRIVE after TURN_DLY cycles.
- DRIVE -> TURN_OFF on oe=0.
- TURN_OFF -> HIZ after TURN_DLY cycles, if oe=0.
- TURN_OFF -> TURN_ON after TURN_DLY cycles, if oe=1.
REQ-021 pad_oe is 1 only in DRIVE; it falls in the same cycle the FSM enters TURN_OFF, which gives break-before-make.
REQ-022 oe=0 during TURN_ON returns to HIZ next cycle; oe=1 during TURN_OFF does not shorten the dead time.
REQ-023 Each bit has a 4-bit delay counter and a target bit. When dout[i] differs from pad_o[i], the counter loads RISE_DLY or FALL_DLY according to direction and counts down; pad_o[i] takes dout[i] when it reaches 0.
REQ-024 If dout[i] returns to pad_o[i] before expiry, the counter cancels and pad_o[i] does not change (glitch filter).
REQ-025 If dout[i] toggles to the opposite value again mid-count, the counter reloads with the delay for the new direction.
REQ-026 A delay of 0 updates pad_o[i] on the next clock edge after the change.
REQ-027 pad_o updates in every FSM state, so data is settled before DRIVE.
REQ-028 Pull outputs are forced to 0 whenever pad_oe=1 or the FSM is in TURN_ON.
- PULL_MODE 1: pad_pu=all ones otherwise.
- PULL_MODE 2: pad_pd=all ones otherwise.
- PULL_MODE 0: both are 0.
REQ-029 Keeper (PULL_MODE 3): on entry to TURN_OFF, keep register = pad_o. In HIZ, keep register = din each cycle. pad_pu=keep and pad_pd=~keep, except in TURN_ON (all 0).
REQ-030 pad_pu and pad_pd are never both 1 on the same bit.
REQ-031 din = pad_i delayed by one cycle in all states.
REQ-032 contention[i] is set (registered) when the FSM is in DRIVE, bit i's counter is idle, and din[i] != pad_o[i] for 2 consecutive cycles; it is sticky until reset.

Reset
REQ-033 With reset=1 at a clock edge, the FSM goes to HIZ and pad_o, din, contention, the keep register and all counters go to 0.
REQ-034 After reset, pad_oe=0 and busy=0. pad_pu and pad_pd follow REQ-028/REQ-029 from keep=0; in mode 3 that gives pad_pd=all ones.
REQ-035 Reset mid-operation (any state, counter active) takes effect at the next edge with no dead-time completion.

Verification
REQ-036 Defaults; oe 0->1 at cycle 0 -> busy=1 for cycles 1-2; pad_oe=1 from cycle 3.
REQ-037 In DRIVE, dout bit0 0->1, then 1->0 after 10 cycles -> pad_o[0] rises 1 cycle after the first change and falls 3 cycles after the second.
REQ-038 dout bit1 pulse high for 1 cycle with RISE_DLY=3 -> pad_o[1] never changes.
REQ-039 PULL_MODE=3, drive 0xA5, drop oe -> pad_oe=0 the next cycle. pad_pu=0xA5 and pad_pd=0x5A from TURN_OFF onward; the keeper then tracks pad_i driven 0x3C.
REQ-040 In DRIVE with pad_o=0xFF, force pad_i=0xFE for 2+ cycles -> contention=0x01, held after pad_i is restored.
REQ-041 Reassert oe in the first TURN_OFF cycle, then assert reset in TURN_ON -> full TURN_DLY dead time, then TURN_ON; reset returns HIZ and zero outputs the next cycle.

Source files
------------

// File: rtl/pad_driver_ctrl.sv
// Bidirectional pad controller: direction FSM with dead time on every turn,
// per-bit rise/fall delay filtering, pull/keeper control and contention detect.
module pad_driver_bit #(
  parameter int RISE_DLY = 1,
  parameter int FALL_DLY = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic drive,
  input  logic sense,
  output logic po,
  output logic cont
);
  logic [3:0] cnt, dly;
  logic       tgt, mis, mism;

  assign dly  = d ? 4'(RISE_DLY) : 4'(FALL_DLY);
  assign mism = drive && (cnt == 4'd0) && (sense != po);

  // cnt==0 means idle; delays of 0 and 1 both land on the sampling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tgt  <= 1'b0;
      po   <= 1'b0;
      mis  <= 1'b0;
      cont <= 1'b0;
    end else begin
      mis <= mism;
      if (mis && mism) cont <= 1'b1;
      if (d == po) begin
        cnt <= '0;
      end else if (cnt == 4'd0 || d != tgt) begin
        tgt <= d;
        if (dly <= 4'd1) begin
          po  <= d;
          cnt <= '0;
        end else begin
          cnt <= dly - 4'd1;
        end
      end else if (cnt == 4'd1) begin
        po  <= tgt;
        cnt <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

module pad_driver_ctrl #(
  parameter int WIDTH     = 8,
  parameter int RISE_DLY  = 1,
  parameter int FALL_DLY  = 3,
  parameter int TURN_DLY  = 2,
  parameter int PULL_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic             pad_oe,
  output logic [WIDTH-1:0] pad_pu,
  output logic [WIDTH-1:0] pad_pd,
  output logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [WIDTH-1:0] contention
);
  typedef enum logic [1:0] {HIZ, TURN_ON, DRIVE, TURN_OFF} state_t;
  localparam logic [3:0] TLOAD = 4'(TURN_DLY - 1);

  state_t           state, nstate;
  logic [3:0]       tcnt, tcnt_nx;
  logic [WIDTH-1:0] keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HIZ;
      tcnt  <= '0;
      din   <= '0;
      keep  <= '0;
    end else begin
      state <= nstate;
      tcnt  <= tcnt_nx;
      din   <= pad_i;
      if (state == DRIVE && !oe) keep <= pad_o;
      else if (state == HIZ)     keep <= din;
    end
  end

  // tcnt counts the remaining dead cycles of the current turn state
  always_comb begin
    nstate  = state;
    tcnt_nx = tcnt;
    case (state)
      HIZ: if (oe) begin
        nstate  = TURN_ON;
        tcnt_nx = TLOAD;
      end
      TURN_ON: begin
        if (!oe)              nstate  = HIZ;
        else if (tcnt == '0)  nstate  = DRIVE;
        else                  tcnt_nx = tcnt - 4'd1;
      end
      DRIVE: if (!oe) begin
        nstate  = TURN_OFF;
        tcnt_nx = TLOAD;
      end
      TURN_OFF: begin
        if (tcnt == '0) begin
          nstate  = oe ? TURN_ON : HIZ;
          tcnt_nx = TLOAD;
        end else begin
          tcnt_nx = tcnt - 4'd1;
        end
      end
      default: nstate = HIZ;
    endcase
  end

  assign pad_oe = (state == DRIVE);
  assign busy   = (state == TURN_ON) || (state == TURN_OFF);

  always_comb begin
    pad_pu = '0;
    pad_pd = '0;
    if (state != DRIVE && state != TURN_ON) begin
      case (PULL_MODE)
        1: pad_pu = '1;
        2: pad_pd = '1;
        3: begin
          pad_pu = keep;
          pad_pd = ~keep;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pad_driver_bit #(.RISE_DLY(RISE_DLY), .FALL_DLY(FALL_DLY)) u_bit (
      .clk  (clk),
      .reset(reset),
      .d    (dout[i]),
      .drive(state == DRIVE),
      .sense(din[i]),
      .po   (pad_o[i]),
      .cont (contention[i])
    );
  end
endmodule
